// File: rtl/multi_sig_checker_pkg.sv
// Shared types and helpers for the multi-channel golden-vs-DUT checker.
//   chk_state_e : checker FSM encoding (matches the 2-bit state output)
//   ch_lsb      : LSB position of a channel inside a packed channel bus
//   popcount    : number of set bits in a (zero-extended) channel vector
package multi_sig_checker_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned POP_W  = 5;
  localparam int unsigned ARM_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    CHECKING = 2'd2,
    HALTED   = 2'd3
  } chk_state_e;

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register used to align golden values with DUT latency.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous flush of all stages
//   din / dout : W-bit input and DEPTH-cycle delayed output (wire when DEPTH=0)
module sig_delay_line #(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Control inputs are intentionally unused in the bypass configuration.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, clr};
    assign dout        = din;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Next stage contents: input enters stage 0, everything moves one along.
    always_comb begin
      stage_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/multi_sig_checker.sv
// Golden-versus-DUT comparator over NUM_CH packed channels.
//   clock2, reset_n       : clock, synchronous active-low reset
//   enable, clear         : checking enable, synchronous clear of all results
//   ch_mask               : per-channel exclusion
//   dut_val/dut_vld       : DUT values and validity (channel c at [c*WIDTH +: WIDTH])
//   gold_val/gold_vld     : golden values and validity, delayed by GOLD_DELAY
//   mismatch, sticky_fail, any_fail, err_count : registered results
//   first_*               : capture of the first failing channel-cycle
//   state                 : IDLE=0, ARMING=1, CHECKING=2, HALTED=3
module multi_sig_checker
  import multi_sig_checker_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned GOLD_DELAY   = 0,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STOP_ON_FAIL = 0,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock2,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] dut_val,
  input  logic [NUM_CH-1:0]       dut_vld,
  input  logic [NUM_CH*WIDTH-1:0] gold_val,
  input  logic [NUM_CH-1:0]       gold_vld,
  output logic [NUM_CH-1:0]       mismatch,
  output logic [NUM_CH-1:0]       sticky_fail,
  output logic                    any_fail,
  output logic [CNT_W-1:0]        err_count,
  output logic                    first_vld,
  output logic [CH_W-1:0]         first_ch,
  output logic [CNT_W-1:0]        first_cycle,
  output logic [WIDTH-1:0]        first_dut,
  output logic [WIDTH-1:0]        first_gold,
  output logic [1:0]              state
);

  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  // Golden path aligned to DUT latency, one delay line per channel.
  logic [NUM_CH*WIDTH-1:0] gold_al;
  logic [NUM_CH-1:0]       gold_vld_al;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_align
    sig_delay_line #(
      .W     (WIDTH + 1),
      .DEPTH (GOLD_DELAY)
    ) u_dly (
      .clk   (clock2),
      .rst_n (reset_n),
      .clr   (clear),
      .din   ({gold_vld[c], gold_val[c*WIDTH +: WIDTH]}),
      .dout  ({gold_vld_al[c], gold_al[c*WIDTH +: WIDTH]})
    );
  end

  chk_state_e        state_q, state_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]  stamp_q, stamp_d;
  logic [NUM_CH-1:0] mismatch_q, mismatch_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic              any_fail_q, any_fail_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              first_vld_q, first_vld_d;
  logic [CH_W-1:0]   first_ch_q, first_ch_d;
  logic [CNT_W-1:0]  first_cycle_q, first_cycle_d;
  logic [WIDTH-1:0]  first_dut_q, first_dut_d;
  logic [WIDTH-1:0]  first_gold_q, first_gold_d;

  logic [NUM_CH-1:0] mm_c;
  logic [SUM_W-1:0]  err_sum;
  logic              found;

  // Next-state, comparison and result update.
  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    stamp_d       = stamp_q;
    mismatch_d    = '0;
    sticky_d      = sticky_q;
    err_d         = err_q;
    first_vld_d   = first_vld_q;
    first_ch_d    = first_ch_q;
    first_cycle_d = first_cycle_q;
    first_dut_d   = first_dut_q;
    first_gold_d  = first_gold_q;
    mm_c          = '0;
    err_sum       = '0;
    found         = 1'b0;

    if (state_q == CHECKING) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mm_c[c] = !ch_mask[c] && dut_vld[c] && gold_vld_al[c] &&
                  (dut_val[ch_lsb(c, WIDTH) +: WIDTH] != gold_al[ch_lsb(c, WIDTH) +: WIDTH]);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          arm_cnt_d = '0;
          state_d   = (GOLD_DELAY == 0) ? CHECKING : ARMING;
        end
      end
      ARMING: begin
        if (!enable) begin
          arm_cnt_d = '0;
          state_d   = IDLE;
        end else if (arm_cnt_q == ARM_W'(GOLD_DELAY - 1)) begin
          arm_cnt_d = '0;
          state_d   = CHECKING;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      CHECKING: begin
        stamp_d = stamp_q + 1'b1;
        if (!enable) begin
          state_d = IDLE;
        end else if ((STOP_ON_FAIL != 0) && (|mm_c)) begin
          state_d = HALTED;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase

    mismatch_d = mm_c;
    sticky_d   = sticky_q | mm_c;

    // Saturating accumulate in a widened sum so the carry is observable.
    err_sum = SUM_W'(err_q) + SUM_W'(popcount(MAX_CH'(mm_c)));
    if (err_sum > SUM_W'({CNT_W{1'b1}})) err_d = '1;
    else                                  err_d = CNT_W'(err_sum);

    // First failure: lowest mismatching channel, only while nothing captured.
    if (!first_vld_q) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (mm_c[c] && !found) begin
          found         = 1'b1;
          first_vld_d   = 1'b1;
          first_ch_d    = CH_W'(c);
          first_cycle_d = stamp_q;
          first_dut_d   = dut_val[ch_lsb(c, WIDTH) +: WIDTH];
          first_gold_d  = gold_al[ch_lsb(c, WIDTH) +: WIDTH];
        end
      end
    end

    // Clear overrides everything computed above, including this cycle's result.
    if (clear) begin
      state_d       = IDLE;
      arm_cnt_d     = '0;
      stamp_d       = '0;
      mismatch_d    = '0;
      sticky_d      = '0;
      err_d         = '0;
      first_vld_d   = 1'b0;
      first_ch_d    = '0;
      first_cycle_d = '0;
      first_dut_d   = '0;
      first_gold_d  = '0;
    end

    any_fail_d = |sticky_d;
  end

  always_ff @(posedge clock2) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      arm_cnt_q     <= '0;
      stamp_q       <= '0;
      mismatch_q    <= '0;
      sticky_q      <= '0;
      any_fail_q    <= 1'b0;
      err_q         <= '0;
      first_vld_q   <= 1'b0;
      first_ch_q    <= '0;
      first_cycle_q <= '0;
      first_dut_q   <= '0;
      first_gold_q  <= '0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      stamp_q       <= stamp_d;
      mismatch_q    <= mismatch_d;
      sticky_q      <= sticky_d;
      any_fail_q    <= any_fail_d;
      err_q         <= err_d;
      first_vld_q   <= first_vld_d;
      first_ch_q    <= first_ch_d;
      first_cycle_q <= first_cycle_d;
      first_dut_q   <= first_dut_d;
      first_gold_q  <= first_gold_d;
    end
  end

  assign state       = state_q;
  assign mismatch    = mismatch_q;
  assign sticky_fail = sticky_q;
  assign any_fail    = any_fail_q;
  assign err_count   = err_q;
  assign first_vld   = first_vld_q;
  assign first_ch    = first_ch_q;
  assign first_cycle = first_cycle_q;
  assign first_dut   = first_dut_q;
  assign first_gold  = first_gold_q;

endmodule

// File: tb/tb_multi_sig_checker.sv
// Directed bench for multi_sig_checker. Four instances share one stimulus
// bus: u0 default, u1 GOLD_DELAY=3, u2 CNT_W=4, u3 STOP_ON_FAIL=1. Each
// scenario starts with a clear and checks only the instance it targets.
module tb_multi_sig_checker;

  logic        clock2;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [3:0]  ch_mask;
  logic [19:0] dut_val;
  logic [3:0]  dut_vld;
  logic [19:0] gold_val;
  logic [3:0]  gold_vld;

  logic [3:0] mm0, mm1, mm2, mm3;
  logic [3:0] sf0, sf1, sf2, sf3;
  logic       af0, af1, af2, af3;
  logic [7:0] ec0, ec1, ec3;
  logic [3:0] ec2;
  logic       fv0, fv1, fv2, fv3;
  logic [1:0] fc0, fc1, fc2, fc3;
  logic [7:0] fy0, fy1, fy3;
  logic [3:0] fy2;
  logic [4:0] fd0, fd1, fd2, fd3;
  logic [4:0] fg0, fg1, fg2, fg3;
  logic [1:0] st0, st1, st2, st3;

  int n_checks = 0;
  int n_pass   = 0;

  multi_sig_checker u0 (
    .clock2(clock2), .reset_n(reset_n), .enable(enable), .clear(clear), .ch_mask(ch_mask),
    .dut_val(dut_val), .dut_vld(dut_vld), .gold_val(gold_val), .gold_vld(gold_vld),
    .mismatch(mm0), .sticky_fail(sf0), .any_fail(af0), .err_count(ec0), .first_vld(fv0),
    .first_ch(fc0), .first_cycle(fy0), .first_dut(fd0), .first_gold(fg0), .state(st0));

  multi_sig_checker #(.GOLD_DELAY(3)) u1 (
    .clock2(clock2), .reset_n(reset_n), .enable(enable), .clear(clear), .ch_mask(ch_mask),
    .dut_val(dut_val), .dut_vld(dut_vld), .gold_val(gold_val), .gold_vld(gold_vld),
    .mismatch(mm1), .sticky_fail(sf1), .any_fail(af1), .err_count(ec1), .first_vld(fv1),
    .first_ch(fc1), .first_cycle(fy1), .first_dut(fd1), .first_gold(fg1), .state(st1));

  multi_sig_checker #(.CNT_W(4)) u2 (
    .clock2(clock2), .reset_n(reset_n), .enable(enable), .clear(clear), .ch_mask(ch_mask),
    .dut_val(dut_val), .dut_vld(dut_vld), .gold_val(gold_val), .gold_vld(gold_vld),
    .mismatch(mm2), .sticky_fail(sf2), .any_fail(af2), .err_count(ec2), .first_vld(fv2),
    .first_ch(fc2), .first_cycle(fy2), .first_dut(fd2), .first_gold(fg2), .state(st2));

  multi_sig_checker #(.STOP_ON_FAIL(1)) u3 (
    .clock2(clock2), .reset_n(reset_n), .enable(enable), .clear(clear), .ch_mask(ch_mask),
    .dut_val(dut_val), .dut_vld(dut_vld), .gold_val(gold_val), .gold_vld(gold_vld),
    .mismatch(mm3), .sticky_fail(sf3), .any_fail(af3), .err_count(ec3), .first_vld(fv3),
    .first_ch(fc3), .first_cycle(fy3), .first_dut(fd3), .first_gold(fg3), .state(st3));

  initial clock2 = 1'b0;
  always #5 clock2 = ~clock2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One rising edge, then settle so registered outputs can be sampled.
  task automatic tick();
    @(posedge clock2);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [4:0] d, input logic [4:0] g);
    dut_val[c*5 +: 5]  = d;
    gold_val[c*5 +: 5] = g;
  endtask

  task automatic set_all(input logic [4:0] d, input logic [4:0] g);
    for (int c = 0; c < 4; c++) set_ch(c, d, g);
  endtask

  // Return every instance to IDLE with fresh results and neutral inputs.
  task automatic start_test();
    enable   = 1'b0;
    clear    = 1'b1;
    ch_mask  = 4'b0000;
    dut_vld  = 4'b1111;
    gold_vld = 4'b1111;
    set_all(5'h00, 5'h00);
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    ch_mask  = 4'b0000;
    dut_vld  = 4'b1111;
    gold_vld = 4'b1111;
    set_all(5'h1F, 5'h00);

    // Reset, then idle with differing values: nothing is checked.
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("rst_state",    32'(st0), 32'd0);
    check("rst_mismatch", 32'(mm0), 32'd0);
    check("rst_sticky",   32'(sf0), 32'd0);
    check("rst_any_fail", 32'(af0), 32'd0);
    check("rst_err",      32'(ec0), 32'd0);
    check("rst_first_vld",32'(fv0), 32'd0);

    // Single mismatch on ch2 at cycle stamp 3.
    start_test();
    enable = 1'b1;
    tick();
    check("single_state", 32'(st0), 32'd2);
    repeat (3) tick();
    set_ch(2, 5'h0A, 5'h0B);
    tick();
    check("single_mismatch",   32'(mm0), 32'b0100);
    check("single_sticky",     32'(sf0), 32'b0100);
    check("single_any_fail",   32'(af0), 32'd1);
    check("single_err",        32'(ec0), 32'd1);
    check("single_first_vld",  32'(fv0), 32'd1);
    check("single_first_ch",   32'(fc0), 32'd2);
    check("single_first_cyc",  32'(fy0), 32'd3);
    check("single_first_dut",  32'(fd0), 32'h0A);
    check("single_first_gold", 32'(fg0), 32'h0B);
    set_ch(2, 5'h0A, 5'h0A);
    tick();
    check("single_pulse_end",  32'(mm0), 32'd0);
    check("single_sticky_hold",32'(sf0), 32'b0100);
    check("single_err_hold",   32'(ec0), 32'd1);

    // Clear in the same cycle as a mismatch: clear wins.
    set_ch(0, 5'h01, 5'h02);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrwin_mismatch", 32'(mm0), 32'd0);
    check("clrwin_err",      32'(ec0), 32'd0);
    check("clrwin_sticky",   32'(sf0), 32'd0);
    check("clrwin_first_vld",32'(fv0), 32'd0);
    check("clrwin_state",    32'(st0), 32'd0);

    // Latency alignment on u1: gold leads dut by 3 (windows 0..10), then by 2.
    start_test();
    enable = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      set_all(5'(k + 1), (k <= 10) ? 5'(k + 4) : 5'(k + 3));
      tick();
      if (k <= 2) check($sformatf("align_arming_%0d", k), 32'(st1), 32'd1);
      if (k == 3) check("align_checking", 32'(st1), 32'd2);
      if (k == 10) begin
        check("align_err_zero",    32'(ec1), 32'd0);
        check("align_sticky_zero", 32'(sf1), 32'd0);
      end
    end
    check("misalign_mismatch", 32'(mm1), 32'hF);
    check("misalign_sticky",   32'(sf1), 32'hF);
    check("misalign_err",      32'(ec1), 32'd12);

    // Masking and validity on u0; unmasking takes effect immediately.
    start_test();
    enable = 1'b1;
    tick();
    set_ch(0, 5'h03, 5'h04);
    set_ch(1, 5'h05, 5'h06);
    set_ch(3, 5'h07, 5'h08);
    dut_vld  = 4'b1110;
    gold_vld = 4'b0111;
    ch_mask  = 4'b0010;
    tick();
    check("mask_mismatch", 32'(mm0), 32'd0);
    check("mask_err",      32'(ec0), 32'd0);
    check("mask_sticky",   32'(sf0), 32'd0);
    ch_mask = 4'b0000;
    tick();
    check("unmask_mismatch", 32'(mm0), 32'b0010);
    check("unmask_err",      32'(ec0), 32'd1);

    // Saturation on u2 (4-bit counter), all channels failing.
    start_test();
    enable = 1'b1;
    tick();
    set_all(5'h01, 5'h02);
    tick();
    check("sat_err_1",      32'(ec2), 32'd4);
    check("sat_first_ch",   32'(fc2), 32'd0);
    check("sat_first_cyc",  32'(fy2), 32'd0);
    check("sat_mismatch",   32'(mm2), 32'hF);
    set_all(5'h03, 5'h04);
    tick();
    tick();
    check("sat_err_3", 32'(ec2), 32'd12);
    tick();
    check("sat_err_4", 32'(ec2), 32'd15);
    tick();
    check("sat_err_5",       32'(ec2), 32'd15);
    check("sat_first_dut",   32'(fd2), 32'h01);
    check("sat_first_gold",  32'(fg2), 32'h02);

    // Stop-on-fail on u3.
    start_test();
    enable = 1'b1;
    tick();
    set_ch(1, 5'h01, 5'h02);
    set_ch(3, 5'h01, 5'h02);
    tick();
    check("stop_state",    32'(st3), 32'd3);
    check("stop_mismatch", 32'(mm3), 32'b1010);
    check("stop_err",      32'(ec3), 32'd2);
    check("stop_first_ch", 32'(fc3), 32'd1);
    tick();
    tick();
    check("halt_err",      32'(ec3), 32'd2);
    check("halt_mismatch", 32'(mm3), 32'd0);
    enable = 1'b0;
    tick();
    check("halt_no_exit",  32'(st3), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("halt_clr_state",    32'(st3), 32'd0);
    check("halt_clr_err",      32'(ec3), 32'd0);
    check("halt_clr_sticky",   32'(sf3), 32'd0);
    check("halt_clr_any_fail", 32'(af3), 32'd0);
    check("halt_clr_first",    32'(fv3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
